vga_face_sequencer: RTL and testbench
=====================================

// Module: vga_face_sequencer
// PURPOSE
//   Parametrised face-selection controller between board switches and the VGA face renderer.
//   - Synchronises and debounces the raw selector.
//   - Clamps it to the number of stored faces.
//   - Commits a new face only on a frame boundary, so a face never tears mid-frame.
//   - Optional auto mode steps through all faces every AUTO_FRAMES frames.
//   - Drives face_select of the VGA subsystem, replacing the direct switch connection.
// PARAMETERS
//   N_FACES          4       number of faces in the renderer, >=2
//   SEL_W            2       selector width, 2**SEL_W >= N_FACES
//   DEBOUNCE_CYCLES  500000  stable-input cycles required before accepting (10 ms @ 50 MHz), >=2
//   AUTO_FRAMES      60      frames per face in auto mode, >=1
//   INIT_FACE        0       face_select value after reset, < N_FACES
// PORTS
//   clk_clk        in   1      pixel-domain system clock
//   reset_reset_n  in   1      asynchronous active-low reset
//   sw_sel         in   SEL_W  raw asynchronous switch selector
//   auto_en        in   1      1 = auto-cycle mode; synchronous, level
//   frame_start    in   1      one-cycle pulse at start of vertical blank, from VGA timing
//   face_select    out  SEL_W  committed face index to the renderer
//   face_changed   out  1      one-cycle pulse, the cycle face_select takes a new value
//   sel_stable     out  SEL_W  debounced, clamped selector (debug/LED)
// BEHAVIOUR
//   Reset (async assert, sync deassert by system)
//     - face_select=INIT_FACE; face_changed=0; sel_stable=0.
//     - Synchroniser, candidate, debounce counter and frame counter all cleared to 0.
//   Synchroniser
//     - 2-flop chain on sw_sel.
//     - sync_sel = output of the second flop.
//   Debounce
//     - Registers: cand, cnt (width clog2(DEBOUNCE_CYCLES)).
//     - If sync_sel != cand: cand <= sync_sel, cnt <= 0.
//     - Else if cnt == DEBOUNCE_CYCLES-1: stable <= cand; cnt holds (saturates).
//     - Else cnt++.
//     - Latency from a clean sw_sel change to the sel_stable update = 2 + DEBOUNCE_CYCLES + 1 cycles.
//     - A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
//   Clamp
//     - sel_stable = (stable >= N_FACES) ? N_FACES-1 : stable. Registered view of stable.
//   Manual commit (auto_en=0)
//     - On a frame_start cycle, if sel_stable != face_select:
//       face_select <= sel_stable and face_changed <= 1 on the same edge.
//     - No change ever occurs outside frame_start cycles.
//     - If frame_start and a sel_stable update fall in the same cycle, the pre-update sel_stable
//       is used; the new value commits on the next frame_start.
//   Auto mode (auto_en=1)
//     - fcnt counts frame_start pulses.
//     - On the pulse where fcnt == AUTO_FRAMES-1: fcnt <= 0, face_changed <= 1, and
//       face_select <= (face_select == N_FACES-1) ? 0 : face_select+1 (wraps).
//     - Switches are ignored in auto mode, but debounce keeps running.
//   Mode change
//     - Any auto_en edge clears fcnt in that cycle; face_select is held.
//     - After auto->manual, the next frame_start commits sel_stable if it differs.
//   Outputs and reset
//     - face_changed is 0 in every other cycle.
//     - face_select is always < N_FACES.
//     - Reset mid-operation returns everything to reset values immediately; a pending commit is lost.
// TESTING (bench params: N_FACES=3, SEL_W=2, DEBOUNCE_CYCLES=4, AUTO_FRAMES=2, INIT_FACE=0)
//   1. Reset, then sw_sel=1 held; frame_start pulsed every 20 cycles
//      -> sel_stable=1 after 7 cycles; face_select=1 at the next frame_start;
//         exactly one face_changed pulse.
//   2. sw_sel 0->2->0, with the 2 held for 3 cycles -> sel_stable stays 0; no face_changed.
//   3. sw_sel=3 (out of range), held
//      -> sel_stable=2; face_select=2 at the next frame_start.
//   4. auto_en=1, six frame_start pulses
//      -> face_select 0->1 at pulse 2, 1->2 at pulse 4, 2->0 at pulse 6 (wrap);
//         face_changed pulses only on those cycles.
//   5. frame_start in the same cycle sel_stable goes 0->1
//      -> face_select stays 0; it becomes 1 at the following frame_start.
//   6. reset_reset_n asserted low mid-frame with face_select=2, auto_en=1
//      -> face_select=0, face_changed=0 immediately (no clock edge needed);
//         after release, the first auto step occurs after 2 more pulses.

Source files
------------

// File: rtl/vga_face_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vga_face_sequencer
// Description : Face-selection controller between the board switches and the
//               VGA face renderer. Synchronises and debounces the raw switch
//               selector, clamps it to the number of stored faces, and
//               commits a new face only on a frame boundary so a face never
//               tears mid-frame. An optional auto mode steps through all
//               faces every AUTO_FRAMES frames.
// Ports       : clk_clk        - pixel-domain system clock
//               reset_reset_n  - asynchronous active-low reset
//               sw_sel         - raw asynchronous switch selector
//               auto_en        - 1 = auto-cycle mode (synchronous level)
//               frame_start    - one-cycle pulse at start of vertical blank
//               face_select    - committed face index to the renderer
//               face_changed   - one-cycle pulse when face_select changes
//               sel_stable     - debounced, clamped selector (debug/LED)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_face_sequencer #(
  parameter int N_FACES         = 4,
  parameter int SEL_W           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_FRAMES     = 60,
  parameter int INIT_FACE       = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [SEL_W-1:0] sw_sel,
  input  logic             auto_en,
  input  logic             frame_start,
  output logic [SEL_W-1:0] face_select,
  output logic             face_changed,
  output logic [SEL_W-1:0] sel_stable
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int FCNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] c_fcnt_last = FCNT_W'(AUTO_FRAMES - 1);
  localparam logic [SEL_W-1:0]  c_last_face = SEL_W'(N_FACES - 1);
  localparam logic [SEL_W-1:0]  c_init_face = SEL_W'(INIT_FACE);

  // Synchroniser
  logic [SEL_W-1:0]  sync1_q, sync1_d;
  logic [SEL_W-1:0]  sync2_q, sync2_d;
  // Debounce
  logic [SEL_W-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  stable_q, stable_d;
  // Commit / auto sequencing
  logic [SEL_W-1:0]  face_q, face_d;
  logic              changed_q, changed_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              auto_q, auto_d;

  logic [SEL_W-1:0]  w_cand_clamped;
  logic              w_mode_edge;

  // The clamp is applied as the debounced value is registered, so the stable
  // register is already the clamped, registered view driven onto sel_stable.
  assign w_cand_clamped = (cand_q > c_last_face) ? c_last_face : cand_q;

  // auto_q resets to 0, so auto_en held high through reset counts as an edge
  // on the first cycle after release; that only clears an already-clear fcnt.
  assign w_mode_edge = (auto_en != auto_q);

  always_comb begin
    sync1_d   = sw_sel;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    face_d    = face_q;
    changed_d = 1'b0;
    fcnt_d    = fcnt_q;
    auto_d    = auto_en;

    // Debounce: any change restarts the count; the count saturates once the
    // candidate has been steady long enough, re-accepting the same value.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == c_cnt_last) begin
      stable_d = w_cand_clamped;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Face commit. A mode change holds the face for that cycle and restarts
    // the frame count. The commit uses stable_q as it was before this edge,
    // so a simultaneous debounce update waits for the next frame_start.
    if (w_mode_edge) begin
      fcnt_d = '0;
    end else if (auto_en) begin
      if (frame_start) begin
        if (fcnt_q == c_fcnt_last) begin
          fcnt_d    = '0;
          changed_d = 1'b1;
          face_d    = (face_q == c_last_face) ? '0 : face_q + SEL_W'(1);
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
    end else if (frame_start && (stable_q != face_q)) begin
      face_d    = stable_q;
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      face_q    <= c_init_face;
      changed_q <= 1'b0;
      fcnt_q    <= '0;
      auto_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      face_q    <= face_d;
      changed_q <= changed_d;
      fcnt_q    <= fcnt_d;
      auto_q    <= auto_d;
    end
  end

  assign face_select  = face_q;
  assign face_changed = changed_q;
  assign sel_stable   = stable_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_face_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_face_sequencer
// Description : Directed self-checking bench for vga_face_sequencer with
//               N_FACES=3, SEL_W=2, DEBOUNCE_CYCLES=4, AUTO_FRAMES=2,
//               INIT_FACE=0. Expected face commits are queued when a frame
//               pulse is driven and compared when face_changed is seen; every
//               other cycle face_select must hold its previous value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_face_sequencer;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw_sel;
  logic       auto_en;
  logic       frame_start;
  logic [1:0] face_select;
  logic       face_changed;
  logic [1:0] sel_stable;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic [1:0] prev_face = 2'd0;

  vga_face_sequencer #(
    .N_FACES        (3),
    .SEL_W          (2),
    .DEBOUNCE_CYCLES(4),
    .AUTO_FRAMES    (2),
    .INIT_FACE      (0)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .sw_sel       (sw_sel),
    .auto_en      (auto_en),
    .frame_start  (frame_start),
    .face_select  (face_select),
    .face_changed (face_changed),
    .sel_stable   (sel_stable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Scoreboard consumer: every face_changed pulse must match the oldest
  // queued expectation; without a pulse face_select must not move.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("changed_in_reset", {31'd0, face_changed}, 32'd0);
      prev_face = 2'd0;
    end else if (face_changed) begin
      if (exp_q.size() == 0) begin
        check("spurious_change", {31'd0, face_changed}, 32'd0);
      end else begin
        check("face_commit", {30'd0, face_select}, {30'd0, exp_q.pop_front()});
      end
      prev_face = face_select;
    end else begin
      check("face_hold", {30'd0, face_select}, {30'd0, prev_face});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n       = 1'b0;
    sw_sel      = 2'd0;
    auto_en     = 1'b0;
    frame_start = 1'b0;
    cycles(3);
    check("reset_face",    {30'd0, face_select}, 32'd0);
    check("reset_changed", {31'd0, face_changed}, 32'd0);
    check("reset_stable",  {30'd0, sel_stable}, 32'd0);
    rst_n = 1'b1;
    cycles(8);

    // 1: clean change to 1, exact debounce latency of 7 cycles
    sw_sel = 2'd1;
    cycles(6);
    check("t1_stable_before", {30'd0, sel_stable}, 32'd0);
    cycles(1);
    check("t1_stable_after", {30'd0, sel_stable}, 32'd1);
    cycles(5);
    check("t1_face_pending", {30'd0, face_select}, 32'd0);
    exp_q.push_back(2'd1);
    pulse_frame();
    check("t1_face", {30'd0, face_select}, 32'd1);
    pulse_frame();  // no further change expected

    // 2: settle on 0, then a 3-cycle glitch to 2 must not pass
    sw_sel = 2'd0;
    cycles(10);
    check("t2_stable0", {30'd0, sel_stable}, 32'd0);
    exp_q.push_back(2'd0);
    pulse_frame();
    sw_sel = 2'd2;
    cycles(3);
    sw_sel = 2'd0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("t2_glitch_stable", {30'd0, sel_stable}, 32'd0);
    end
    pulse_frame();
    check("t2_face", {30'd0, face_select}, 32'd0);

    // 3: out-of-range selector clamps to the last face
    sw_sel = 2'd3;
    cycles(10);
    check("t3_clamp", {30'd0, sel_stable}, 32'd2);
    exp_q.push_back(2'd2);
    pulse_frame();
    check("t3_face", {30'd0, face_select}, 32'd2);

    // 4: auto mode from face 0; switches ignored but still debounced
    sw_sel = 2'd0;
    cycles(10);
    exp_q.push_back(2'd0);
    pulse_frame();
    auto_en = 1'b1;
    sw_sel  = 2'd2;
    cycles(2);
    for (int p = 1; p <= 6; p++) begin
      if (p == 2) exp_q.push_back(2'd1);
      if (p == 4) exp_q.push_back(2'd2);
      if (p == 6) exp_q.push_back(2'd0);
      pulse_frame();
      check("t4_auto_face", {30'd0, face_select}, (p < 2) ? 32'd0 : (p < 4) ? 32'd1 : (p < 6) ? 32'd2 : 32'd0);
      cycles(3);
    end
    check("t4_stable_tracks_sw", {30'd0, sel_stable}, 32'd2);

    // auto -> manual: next frame commits the differing selector
    auto_en = 1'b0;
    cycles(2);
    exp_q.push_back(2'd2);
    pulse_frame();
    check("t4_manual_commit", {30'd0, face_select}, 32'd2);
    sw_sel = 2'd0;
    cycles(10);
    exp_q.push_back(2'd0);
    pulse_frame();

    // 5: frame_start on the same edge sel_stable goes 0->1
    sw_sel = 2'd1;
    cycles(6);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("t5_stable_new", {30'd0, sel_stable}, 32'd1);
    check("t5_face_held", {30'd0, face_select}, 32'd0);
    cycles(3);
    exp_q.push_back(2'd1);
    pulse_frame();
    check("t5_face_next", {30'd0, face_select}, 32'd1);

    // 6: asynchronous reset mid-frame with face 2 in auto mode
    auto_en = 1'b1;
    cycles(2);
    pulse_frame();
    exp_q.push_back(2'd2);
    pulse_frame();
    check("t6_face_before", {30'd0, face_select}, 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_face",    {30'd0, face_select}, 32'd0);
    check("t6_async_changed", {31'd0, face_changed}, 32'd0);
    check("t6_async_stable",  {30'd0, sel_stable}, 32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    pulse_frame();
    check("t6_first_pulse", {30'd0, face_select}, 32'd0);
    exp_q.push_back(2'd1);
    pulse_frame();
    check("t6_second_pulse", {30'd0, face_select}, 32'd1);
    cycles(4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
